// File: rtl/ddot_vec_feeder_pkg.sv
// Shared definitions for the dot-product vector feeder: FSM encoding, lane
// geometry and the tail-mask lane predicate.
package ddot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int          LANES   = 4;
  localparam logic [31:0] FP_ZERO = 32'h0;

  // Lane idx carries real data when fewer than cnt lanes precede it.
  function automatic logic lane_on(input logic [2:0] cnt, input int idx);
    return int'(cnt) > idx;
  endfunction

endpackage

// File: rtl/ddot_vec_feeder_lane_mask.sv
// Zeroes lanes at or above the valid-lane count and registers the result,
// so a beat appears one cycle after its memory data.
module ddot_lane_mask
  import ddot_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic [2:0]              cnt,
  input  logic [LANES*DATA_W-1:0] din,
  output logic                    ready,
  output logic [LANES*DATA_W-1:0] dout
);

  logic ready_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_reg <= 1'b0;
    else      ready_reg <= vld;
  end

  assign ready = ready_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] lane_reg;
      logic [DATA_W-1:0] lane_next;

      assign lane_next = (vld && lane_on(cnt, gi)) ? din[gi*DATA_W +: DATA_W]
                                                   : DATA_W'(FP_ZERO);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) lane_reg <= '0;
        else      lane_reg <= lane_next;
      end

      assign dout[gi*DATA_W +: DATA_W] = lane_reg;
    end
  endgenerate

endmodule

// File: rtl/ddot_vec_feeder.sv
// Streams x[] and y[] from 4-lane memories as back-to-back beats (padded to an
// even count) and pulses done once every paired partial result has returned.
module ddot_vec_feeder
  import ddot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [ADDR_W-1:0]       x_base,
  input  logic [ADDR_W-1:0]       y_base,
  output logic                    x_rd_en,
  output logic [ADDR_W-1:0]       x_addr,
  input  logic [LANES*DATA_W-1:0] x_rd_data,
  output logic                    y_rd_en,
  output logic [ADDR_W-1:0]       y_addr,
  input  logic [LANES*DATA_W-1:0] y_rd_data,
  output logic                    ready,
  output logic [DATA_W-1:0]       x0,
  output logic [DATA_W-1:0]       x1,
  output logic [DATA_W-1:0]       x2,
  output logic [DATA_W-1:0]       x3,
  output logic [DATA_W-1:0]       y0,
  output logic [DATA_W-1:0]       y1,
  output logic [DATA_W-1:0]       y2,
  output logic [DATA_W-1:0]       y3,
  input  logic                    dot_vld,
  output logic                    busy,
  output logic                    done
);

  // One extra bit keeps (len+3) from overflowing at the maximum length.
  localparam int CW = LEN_W + 1;

  state_t            state_reg, state_next;
  logic [CW-1:0]     beats_reg, beats_next;
  logic [CW-1:0]     issue_reg, issue_next;
  logic [CW-1:0]     k_reg, k_next;
  logic [CW-1:0]     res_cnt_reg, res_cnt_next;
  logic [1:0]        tail_reg, tail_next;
  logic [ADDR_W-1:0] x_base_reg, x_base_next;
  logic [ADDR_W-1:0] y_base_reg, y_base_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              s1_vld_reg, s1_vld_next;
  logic [2:0]        s1_cnt_reg, s1_cnt_next;

  logic              rd_en;
  logic [CW-1:0]     beats_in;
  logic [CW-1:0]     exp_res;
  logic [CW-1:0]     res_sum;
  logic              x_ready, y_ready;
  logic [LANES*DATA_W-1:0] x_lanes, y_lanes;

  assign beats_in = (CW'(len) + CW'(3)) >> 2;
  assign exp_res  = issue_reg >> 1;
  assign res_sum  = res_cnt_reg + CW'(dot_vld);
  assign rd_en    = (state_reg == ISSUE) && (k_reg < beats_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      beats_reg   <= '0;
      issue_reg   <= '0;
      k_reg       <= '0;
      res_cnt_reg <= '0;
      tail_reg    <= '0;
      x_base_reg  <= '0;
      y_base_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      s1_vld_reg  <= 1'b0;
      s1_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      beats_reg   <= beats_next;
      issue_reg   <= issue_next;
      k_reg       <= k_next;
      res_cnt_reg <= res_cnt_next;
      tail_reg    <= tail_next;
      x_base_reg  <= x_base_next;
      y_base_reg  <= y_base_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      s1_vld_reg  <= s1_vld_next;
      s1_cnt_reg  <= s1_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    beats_next   = beats_reg;
    issue_next   = issue_reg;
    k_next       = k_reg;
    res_cnt_next = res_cnt_reg;
    tail_next    = tail_reg;
    x_base_next  = x_base_reg;
    y_base_next  = y_base_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    s1_vld_next  = 1'b0;
    s1_cnt_next  = 3'd0;

    case (state_reg)
      IDLE: begin
        // done_reg still high means FIN was last cycle; start waits one more.
        if (start && !done_reg) begin
          beats_next   = beats_in;
          issue_next   = beats_in + CW'(beats_in[0]);
          tail_next    = len[1:0];
          x_base_next  = x_base;
          y_base_next  = y_base;
          k_next       = '0;
          res_cnt_next = '0;
          busy_next    = 1'b1;
          state_next   = (len == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        s1_vld_next = 1'b1;
        if (rd_en)
          s1_cnt_next = ((k_reg == beats_reg - CW'(1)) && (tail_reg != 2'd0))
                        ? {1'b0, tail_reg} : 3'd4;
        k_next = k_reg + CW'(1);
        if (dot_vld) res_cnt_next = res_sum;
        if (k_reg == issue_reg - CW'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (dot_vld) res_cnt_next = res_sum;
        if (res_sum >= exp_res) state_next = FIN;
      end
      FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  ddot_lane_mask #(.DATA_W(DATA_W)) u_x_mask (
    .clk   (clk),
    .rst   (rst),
    .vld   (s1_vld_reg),
    .cnt   (s1_cnt_reg),
    .din   (x_rd_data),
    .ready (x_ready),
    .dout  (x_lanes)
  );

  ddot_lane_mask #(.DATA_W(DATA_W)) u_y_mask (
    .clk   (clk),
    .rst   (rst),
    .vld   (s1_vld_reg),
    .cnt   (s1_cnt_reg),
    .din   (y_rd_data),
    .ready (y_ready),
    .dout  (y_lanes)
  );

  assign x_rd_en = rd_en;
  assign y_rd_en = rd_en;
  assign x_addr  = rd_en ? x_base_reg + ADDR_W'(k_reg) : '0;
  assign y_addr  = rd_en ? y_base_reg + ADDR_W'(k_reg) : '0;
  assign ready   = x_ready & y_ready;
  assign busy    = busy_reg;
  assign done    = done_reg;

  assign x0 = x_lanes[0*DATA_W +: DATA_W];
  assign x1 = x_lanes[1*DATA_W +: DATA_W];
  assign x2 = x_lanes[2*DATA_W +: DATA_W];
  assign x3 = x_lanes[3*DATA_W +: DATA_W];
  assign y0 = y_lanes[0*DATA_W +: DATA_W];
  assign y1 = y_lanes[1*DATA_W +: DATA_W];
  assign y2 = y_lanes[2*DATA_W +: DATA_W];
  assign y3 = y_lanes[3*DATA_W +: DATA_W];

endmodule

// File: tb/tb_ddot_vec_feeder.sv
// Directed bench for ddot_vec_feeder: expected reads and beats are queued at
// stimulus time and popped as the DUT produces them; a toy datapath returns dot_vld.
module tb_ddot_vec_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [10:0]  len;
  logic [9:0]   x_base, y_base, x_addr, y_addr;
  logic         x_rd_en, y_rd_en, ready, busy, done;
  logic [127:0] x_rd_data = '0;
  logic [127:0] y_rd_data = '0;
  logic [31:0]  x0, x1, x2, x3, y0, y1, y2, y3;
  logic         dot_vld = 1'b0;
  logic [255:0] obs_lanes;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rd, n_rdy, n_busy, n_done, n_dot;
  int first_rd, first_rdy, last_rdy, last_dot, done_cyc, start_cyc;
  int mon_a;
  logic       pair = 1'b0;
  logic [2:0] pend = '0;

  int           addr_q[$];
  logic [255:0] beat_q[$];

  always #5 clk = ~clk;

  ddot_vec_feeder dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .x_base(x_base), .y_base(y_base),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_rd_data(x_rd_data),
    .y_rd_en(y_rd_en), .y_addr(y_addr), .y_rd_data(y_rd_data),
    .ready(ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .dot_vld(dot_vld), .busy(busy), .done(done)
  );

  assign obs_lanes = {y3, y2, y1, y0, x3, x2, x1, x0};

  function automatic logic [127:0] mkword(input logic [31:0] tag, input int a);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[32*i +: 32] = tag + 32'(a * 16 + i);
    return w;
  endfunction

  // Read-only memories with one-cycle registered read.
  always @(posedge clk) begin
    if (x_rd_en) x_rd_data <= mkword(32'hA000_0000, int'(x_addr));
    if (y_rd_en) y_rd_data <= mkword(32'hB000_0000, int'(y_addr));
  end

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor plus toy datapath: every second beat returns dot_vld 3 cycles later.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pend    = '0;
      pair    = 1'b0;
      dot_vld = 1'b0;
    end else begin
      dot_vld = pend[0];
      if (pend[0]) begin
        n_dot++;
        last_dot = cyc;
      end
      pend = pend >> 1;
      chk_int("rd_en_pair", int'(y_rd_en), int'(x_rd_en));
      if (x_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        chk_int("rd_expected", int'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) begin
          mon_a = addr_q.pop_front();
          chk_int("x_addr", int'(x_addr), mon_a >> 16);
          chk_int("y_addr", int'(y_addr), mon_a & 1023);
        end
      end
      if (ready) begin
        n_rdy++;
        if (first_rdy < 0) first_rdy = cyc;
        last_rdy = cyc;
        chk_int("beat_expected", int'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) chk_vec("beat_lanes", obs_lanes, beat_q.pop_front());
        pair = ~pair;
        if (!pair) pend[2] = 1'b1;
      end else begin
        chk_vec("idle_lanes", obs_lanes, '0);
      end
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    n_rd = 0; n_rdy = 0; n_busy = 0; n_done = 0; n_dot = 0;
    first_rd = -1; first_rdy = -1; last_rdy = -1; last_dot = -1; done_cyc = -1;
  endtask

  task automatic push_exp(input int l, input int xb, input int yb);
    int beats, issue, tail;
    logic [127:0] xw, yw;
    beats = (l + 3) / 4;
    issue = beats + beats % 2;
    tail  = l % 4;
    for (int k = 0; k < beats; k++)
      addr_q.push_back((((xb + k) % 1024) << 16) | ((yb + k) % 1024));
    for (int k = 0; k < issue; k++) begin
      xw = '0;
      yw = '0;
      if (k < beats) begin
        xw = mkword(32'hA000_0000, (xb + k) % 1024);
        yw = mkword(32'hB000_0000, (yb + k) % 1024);
        if (k == beats - 1 && tail != 0)
          for (int i = tail; i < 4; i++) begin
            xw[32*i +: 32] = 32'h0;
            yw[32*i +: 32] = 32'h0;
          end
      end
      beat_q.push_back({yw, xw});
    end
  endtask

  task automatic run_txn(input int l, input int xb, input int yb, input bit inject);
    int beats, issue, t0;
    beats = (l + 3) / 4;
    issue = beats + beats % 2;
    clear_stats();
    push_exp(l, xb, yb);
    @(posedge clk); #1;
    start = 1'b1; len = 11'(l); x_base = 10'(xb); y_base = 10'(yb);
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = 0;
    while (n_done == 0 && t0 < 3000) begin
      @(posedge clk); #1;
      t0++;
      start = 1'b0;
      if (inject && t0 == 1) begin
        start = 1'b1; len = 11'd100; x_base = 10'h3A0; y_base = 10'h3B0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk_int("done_count", n_done, 1);
    chk_int("rd_count", n_rd, beats);
    chk_int("beat_count", n_rdy, issue);
    chk_int("dot_count", n_dot, issue / 2);
    chk_int("addr_q_empty", int'(addr_q.size()), 0);
    chk_int("beat_q_empty", int'(beat_q.size()), 0);
    chk_int("busy_cycles", n_busy, done_cyc - start_cyc - 1);
    if (l == 0) begin
      chk_int("len0_done_lat", done_cyc - start_cyc, 2);
      chk_int("len0_busy", n_busy, 1);
    end else begin
      chk_int("first_rd_lat", first_rd - start_cyc, 1);
      chk_int("ready_lat", first_rdy - first_rd, 2);
      chk_int("beats_contig", last_rdy - first_rdy, issue - 1);
      chk_int("done_after_dot", done_cyc - last_dot, 2);
    end
    $display("txn len=%0d x_base=%h y_base=%h beats=%0d issue=%0d done_cyc=%0d checks=%0d",
             l, xb, yb, beats, issue, done_cyc, n_chk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; x_base = '0; y_base = '0;
    clear_stats();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_ctrl", int'({x_rd_en, y_rd_en, x_addr, y_addr, ready, busy, done}), 0);
    chk_vec("rst_lanes", obs_lanes, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_txn(8, 'h000, 'h010, 1'b0);
    run_txn(5, 'h020, 'h030, 1'b0);
    run_txn(3, 'h040, 'h050, 1'b0);
    run_txn(0, 'h060, 'h070, 1'b0);
    run_txn(12, 'h3FF, 'h100, 1'b0);
    run_txn(24, 'h060, 'h070, 1'b1);

    // Abort a long transfer with an asynchronous reset mid-cycle.
    clear_stats();
    push_exp(64, 5, 9);
    @(posedge clk); #1;
    start = 1'b1; len = 11'd64; x_base = 10'd5; y_base = 10'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk_int("abort_ctrl", int'({x_rd_en, y_rd_en, x_addr, y_addr, ready, busy, done}), 0);
    chk_vec("abort_lanes", obs_lanes, '0);
    addr_q.delete();
    beat_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_int("abort_no_done", n_done, 0);
    $display("txn aborted len=64 by reset, done pulses=%0d", n_done);

    run_txn(8, 'h080, 'h090, 1'b0);
    run_txn(2047, 'h000, 'h200, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
